// File: rtl/system_manager_cpu_ocimem_arbiter.sv
// OCI debug RAM sequencer: shares a single-port RAM between JTAG host commands
// and the Avalon debug_mem_slave, one RAM cycle at a time through a single FSM.
module system_manager_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  input  logic [3:0]        av_byteenable,
  input  logic              av_debugaccess,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_byteenable,
  output logic [DATA_W-1:0] ram_wrdata,
  output logic              ram_wr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_rddata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun
);

  typedef enum logic [2:0] {IDLE, J_RD, J_RDW, J_WR, A_RD, A_RDW, A_WR, A_ACK} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   jtag_addr;
  logic                jpend;
  logic                jpend_wr;
  logic [DATA_W-1:0]   jpayload;
  logic                last_av;
  logic [ADDR_W-1:0]   av_addr_q;
  logic [DATA_W-1:0]   av_wd_q;
  logic [3:0]          av_be_q;
  logic                av_dbg_q;

  logic any_strobe, lose, av_req;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  // More than one strobe in a cycle: the lower-priority ones are lost.
  assign lose = (take_action_ocimem_a & (take_no_action_ocimem_a | take_action_ocimem_b)) |
                (take_no_action_ocimem_a & take_action_ocimem_b);

  assign av_waitrequest = (state != A_ACK);
  assign av_req         = (av_read | av_write) & av_waitrequest;
  assign jtag_busy      = jpend;

  always_comb begin
    ram_rd         = (state == J_RD) || (state == A_RD);
    ram_wr         = (state == J_WR) || ((state == A_WR) && av_dbg_q);
    ram_addr       = jtag_addr;
    ram_wrdata     = jpayload;
    ram_byteenable = 4'h0;
    if (state == A_RD || state == A_WR) ram_addr = av_addr_q;
    if (state == A_WR) begin
      ram_wrdata     = av_wd_q;
      ram_byteenable = av_be_q;
    end else if (state == J_WR || state == J_RD) begin
      ram_byteenable = 4'hF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      jtag_addr    <= '0;
      jpend        <= 1'b0;
      jpend_wr     <= 1'b0;
      jpayload     <= '0;
      last_av      <= 1'b1;
      av_addr_q    <= '0;
      av_wd_q      <= '0;
      av_be_q      <= '0;
      av_dbg_q     <= 1'b0;
      av_readdata  <= '0;
      MonDReg      <= '0;
      jtag_overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Round-robin on contention: the side not served last goes first.
          if (jpend && (!av_req || last_av)) begin
            last_av <= 1'b0;
            state   <= jpend_wr ? J_WR : J_RD;
          end else if (av_req) begin
            last_av   <= 1'b1;
            av_addr_q <= av_address;
            av_wd_q   <= av_writedata;
            av_be_q   <= av_byteenable;
            av_dbg_q  <= av_debugaccess;
            state     <= av_read ? A_RD : A_WR;
          end
        end
        J_RD:  state <= J_RDW;
        J_RDW: begin
          MonDReg   <= ram_rddata;
          jtag_addr <= jtag_addr + 1'b1;
          jpend     <= 1'b0;
          state     <= IDLE;
        end
        J_WR: begin
          jtag_addr <= jtag_addr + 1'b1;
          jpend     <= 1'b0;
          state     <= IDLE;
        end
        A_RD:  state <= A_RDW;
        A_RDW: begin
          av_readdata <= ram_rddata;
          state       <= A_ACK;
        end
        A_WR:  state <= A_ACK;
        A_ACK: state <= IDLE;
        default: state <= IDLE;
      endcase

      // FSM only clears jpend while it is set; strobes only act while it is clear.
      if (any_strobe) begin
        if (jpend) begin
          jtag_overrun <= 1'b1;
        end else begin
          if (lose) jtag_overrun <= 1'b1;
          if (take_action_ocimem_a) begin
            jtag_addr <= jdo[ADDR_W+1:2];
            if (jdo[35]) begin
              jpend    <= 1'b1;
              jpend_wr <= 1'b0;
            end
          end else if (take_no_action_ocimem_a) begin
            jpend    <= 1'b1;
            jpend_wr <= 1'b0;
          end else begin
            jpend    <= 1'b1;
            jpend_wr <= 1'b1;
            jpayload <= jdo[34:3];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_system_manager_cpu_ocimem_arbiter.sv
// Bench for the OCI RAM arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level shadow memory.
module tb_system_manager_cpu_ocimem_arbiter;
  localparam int ADDR_W = 8;

  logic        clk, reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [7:0]  av_address;
  logic        av_read, av_write, av_debugaccess;
  logic [31:0] av_writedata, av_readdata;
  logic [3:0]  av_byteenable, ram_byteenable;
  logic        av_waitrequest, ram_wr, ram_rd, jtag_busy, jtag_overrun;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wrdata, ram_rddata, MonDReg;

  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  logic [7:0]  wr_log[$];
  logic [31:0] mem[256];
  logic [31:0] shadow[256];

  system_manager_cpu_ocimem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable),
    .av_debugaccess(av_debugaccess), .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest), .ram_addr(ram_addr),
    .ram_byteenable(ram_byteenable), .ram_wrdata(ram_wrdata),
    .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_rddata(ram_rddata),
    .MonDReg(MonDReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_wr)
      for (int i = 0; i < 4; i++)
        if (ram_byteenable[i]) mem[ram_addr][8*i +: 8] = ram_wrdata[8*i +: 8];
    if (ram_rd) ram_rddata <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_wr) wr_log.push_back(ram_addr);
      if (ram_rd) rd_cnt++;
      if (ram_rd && ram_wr) begin
        bad++;
        $display("FAIL strobe_overlap: ram_rd=%b ram_wr=%b want not both", ram_rd, ram_wr);
      end
    end
  end

  function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
    logic [37:0] j;
    j = '0;
    j[ADDR_W+1:2] = a;
    j[35] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
    av_address = '0; av_read = 0; av_write = 0; av_writedata = '0;
    av_byteenable = '0; av_debugaccess = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic jstrobe(input logic sa, input logic sna, input logic sb, input logic [37:0] j);
    take_action_ocimem_a = sa; take_no_action_ocimem_a = sna; take_action_ocimem_b = sb;
    jdo = j;
    tick();
    take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
  endtask

  task automatic wait_jtag_idle();
    int n = 0;
    while (jtag_busy && n < 20) begin tick(); n++; end
    if (jtag_busy) begin
      total++; bad++;
      $display("FAIL jtag_timeout: busy=%b after %0d cycles want 0", jtag_busy, n);
    end
  endtask

  // One Avalon transfer held until waitrequest drops; lat counts cycles to ack.
  task automatic av_xfer(input logic rd, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic dbg,
                         output logic [31:0] rdata, output int lat, output logic wr_after);
    av_address = a; av_read = rd; av_write = !rd; av_writedata = d;
    av_byteenable = be; av_debugaccess = dbg;
    lat = 0;
    do begin tick(); lat++; end while (av_waitrequest && lat < 20);
    if (av_waitrequest) begin
      total++; bad++;
      $display("FAIL av_timeout: waitrequest=%b after %0d cycles want 0", av_waitrequest, lat);
    end
    rdata = av_readdata;
    av_read = 0; av_write = 0;
    tick();
    wr_after = av_waitrequest;
  endtask

  task automatic test_reset();
    do_reset();
    total += 6;
    if (av_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_waitreq: got %b want 1", av_waitrequest); end
    if (MonDReg !== 32'h0) begin bad++; $display("FAIL rst_mondreg: got %h want 0", MonDReg); end
    if (jtag_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", jtag_busy); end
    if (jtag_overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %b want 0", jtag_overrun); end
    if ({ram_rd, ram_wr} !== 2'b00) begin bad++; $display("FAIL rst_strobes: got %b want 00", {ram_rd, ram_wr}); end
    if (av_readdata !== 32'h0) begin bad++; $display("FAIL rst_readdata: got %h want 0", av_readdata); end
  endtask

  task automatic test_jtag_read();
    int bc = 0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h11] = 32'h12345678;
    jstrobe(1, 0, 0, jdo_a(8'h10, 1));
    while (jtag_busy && bc < 10) begin
      if (bc < 2 && MonDReg !== 32'h0) begin
        total++; bad++; $display("FAIL jrd_early: got %h want 0 at cycle %0d", MonDReg, bc);
      end
      bc++;
      tick();
    end
    total += 3;
    if (bc != 3) begin bad++; $display("FAIL jrd_busy_len: got %0d want 3", bc); end
    if (MonDReg !== 32'hDEADBEEF) begin bad++; $display("FAIL jrd_data: got %h want deadbeef", MonDReg); end
    jstrobe(0, 1, 0, '0);
    wait_jtag_idle();
    if (MonDReg !== 32'h12345678) begin bad++; $display("FAIL jrd_incr: got %h want 12345678", MonDReg); end
  endtask

  task automatic test_jtag_write_wrap();
    jstrobe(1, 0, 0, jdo_a(8'hFF, 0));
    total += 4;
    if (jtag_busy !== 1'b0) begin bad++; $display("FAIL jwr_load_busy: got %b want 0", jtag_busy); end
    jstrobe(0, 0, 1, jdo_b(32'h1));
    wait_jtag_idle();
    jstrobe(0, 0, 1, jdo_b(32'h2));
    wait_jtag_idle();
    if (mem[8'hFF] !== 32'h1) begin bad++; $display("FAIL jwr_ff: got %h want 1", mem[8'hFF]); end
    if (mem[8'h00] !== 32'h2) begin bad++; $display("FAIL jwr_wrap: got %h want 2", mem[8'h00]); end
    if (jtag_overrun !== 1'b0) begin bad++; $display("FAIL jwr_overrun: got %b want 0", jtag_overrun); end
  endtask

  task automatic test_av_read();
    logic [31:0] rd; int lat; logic wa;
    mem[8'h20] = 32'hA5A5A5A5;
    av_xfer(1, 8'h20, '0, 4'hF, 1, rd, lat, wa);
    total += 3;
    if (lat != 3) begin bad++; $display("FAIL avrd_lat: got %0d want 3", lat); end
    if (rd !== 32'hA5A5A5A5) begin bad++; $display("FAIL avrd_data: got %h want a5a5a5a5", rd); end
    if (wa !== 1'b1) begin bad++; $display("FAIL avrd_ack_len: waitreq got %b want 1", wa); end
  endtask

  task automatic test_debugaccess();
    logic [31:0] rd; int lat; logic wa; int n;
    n = wr_log.size();
    mem[8'h60] = 32'h11111111;
    av_xfer(0, 8'h60, 32'hCAFE, 4'hF, 0, rd, lat, wa);
    total += 5;
    if (lat != 2) begin bad++; $display("FAIL dbg_lat: got %0d want 2", lat); end
    if (wa !== 1'b1) begin bad++; $display("FAIL dbg_ack_len: waitreq got %b want 1", wa); end
    if (wr_log.size() != n) begin bad++; $display("FAIL dbg_ram_wr: got %0d writes want 0", wr_log.size() - n); end
    if (mem[8'h60] !== 32'h11111111) begin bad++; $display("FAIL dbg_mem: got %h want 11111111", mem[8'h60]); end
    if (av_readdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL dbg_rd_hold: got %h want a5a5a5a5", av_readdata); end
  endtask

  task automatic test_arbitration();
    logic [31:0] rd; int lat; logic wa; int base;
    logic [7:0] exp_ord[7] = '{8'h40, 8'h50, 8'h41, 8'h51, 8'h42, 8'h52, 8'h43};
    do_reset();
    base = wr_log.size();
    jstrobe(1, 0, 0, jdo_a(8'h40, 0));
    for (int r = 0; r < 2; r++) begin
      jstrobe(0, 0, 1, jdo_b(32'h100 + r));
      av_xfer(0, 8'h50 + 8'(r), 32'h200 + r, 4'hF, 1, rd, lat, wa);
      wait_jtag_idle();
    end
    jstrobe(0, 0, 1, jdo_b(32'h102));
    wait_jtag_idle();
    jstrobe(0, 0, 1, jdo_b(32'h103));
    av_xfer(0, 8'h52, 32'h202, 4'hF, 1, rd, lat, wa);
    wait_jtag_idle();
    total++;
    if (wr_log.size() - base != 7) begin
      bad++; $display("FAIL arb_count: got %0d writes want 7", wr_log.size() - base);
    end else begin
      for (int i = 0; i < 7; i++) begin
        total++;
        if (wr_log[base+i] !== exp_ord[i]) begin
          bad++; $display("FAIL arb_order[%0d]: got %h want %h", i, wr_log[base+i], exp_ord[i]);
        end
      end
    end
  endtask

  task automatic test_priority();
    int n, rc;
    do_reset();
    mem[8'h30] = 32'h00000077;
    n = wr_log.size(); rc = rd_cnt;
    jstrobe(1, 0, 1, jdo_a(8'h30, 1));
    wait_jtag_idle();
    total += 4;
    if (MonDReg !== 32'h77) begin bad++; $display("FAIL prio_data: got %h want 77", MonDReg); end
    if (jtag_overrun !== 1'b1) begin bad++; $display("FAIL prio_overrun: got %b want 1", jtag_overrun); end
    if (wr_log.size() != n) begin bad++; $display("FAIL prio_nowrite: got %0d writes want 0", wr_log.size() - n); end
    if (rd_cnt != rc + 1) begin bad++; $display("FAIL prio_reads: got %0d want 1", rd_cnt - rc); end
  endtask

  task automatic test_overrun_reset();
    int rc; logic [31:0] rd; int lat; logic wa;
    do_reset();
    mem[8'h70] = 32'h0000ABCD;
    mem[8'h71] = 32'h00005555;
    mem[8'h91] = 32'h00009999;
    jstrobe(1, 0, 0, jdo_a(8'h70, 0));
    rc = rd_cnt;
    jstrobe(0, 1, 0, '0);
    jstrobe(0, 1, 0, '0);
    jstrobe(1, 0, 0, jdo_a(8'h90, 0));
    wait_jtag_idle();
    total += 4;
    if (rd_cnt != rc + 1) begin bad++; $display("FAIL ovr_reads: got %0d want 1", rd_cnt - rc); end
    if (jtag_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", jtag_overrun); end
    if (MonDReg !== 32'hABCD) begin bad++; $display("FAIL ovr_data: got %h want abcd", MonDReg); end
    jstrobe(0, 1, 0, '0);
    wait_jtag_idle();
    if (MonDReg !== 32'h5555) begin bad++; $display("FAIL ovr_addr_kept: got %h want 5555", MonDReg); end
    // Abort an Avalon read in its data-capture cycle.
    av_address = 8'h20; av_read = 1; av_byteenable = 4'hF;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    total += 5;
    if (av_waitrequest !== 1'b1) begin bad++; $display("FAIL abort_waitreq: got %b want 1", av_waitrequest); end
    if ({ram_rd, ram_wr} !== 2'b00) begin bad++; $display("FAIL abort_strobes: got %b want 00", {ram_rd, ram_wr}); end
    if (MonDReg !== 32'h0) begin bad++; $display("FAIL abort_mondreg: got %h want 0", MonDReg); end
    if (jtag_overrun !== 1'b0) begin bad++; $display("FAIL abort_overrun: got %b want 0", jtag_overrun); end
    if (av_readdata !== 32'h0) begin bad++; $display("FAIL abort_readdata: got %h want 0", av_readdata); end
    av_read = 0;
    #1;
    reset_n = 1'b1;
    tick();
    av_xfer(1, 8'h20, '0, 4'hF, 1, rd, lat, wa);
    total += 2;
    if (lat != 3) begin bad++; $display("FAIL abort_relat: got %0d want 3", lat); end
    if (rd !== mem[8'h20]) begin bad++; $display("FAIL abort_redata: got %h want %h", rd, mem[8'h20]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, d; int lat; logic wa; logic [7:0] a; logic [3:0] be; logic dbg;
    int diffs = 0;
    do_reset();
    for (int i = 0; i < 256; i++) begin mem[i] = $urandom; shadow[i] = mem[i]; end
    for (int it = 0; it < 60; it++) begin
      a = 8'($urandom); d = $urandom;
      case ($urandom_range(0, 3))
        0: begin
          be = 4'($urandom); dbg = ($urandom_range(0, 3) != 0);
          av_xfer(0, a, d, be, dbg, rd, lat, wa);
          total++;
          if (lat != 2) begin bad++; $display("FAIL rnd_avwr_lat: got %0d want 2", lat); end
          if (dbg) for (int b = 0; b < 4; b++) if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
        end
        1: begin
          av_xfer(1, a, '0, 4'hF, 1, rd, lat, wa);
          total += 2;
          if (lat != 3) begin bad++; $display("FAIL rnd_avrd_lat: got %0d want 3", lat); end
          if (rd !== shadow[a]) begin bad++; $display("FAIL rnd_avrd[%h]: got %h want %h", a, rd, shadow[a]); end
        end
        2: begin
          jstrobe(1, 0, 0, jdo_a(a, 1));
          wait_jtag_idle();
          total++;
          if (MonDReg !== shadow[a]) begin bad++; $display("FAIL rnd_jrd[%h]: got %h want %h", a, MonDReg, shadow[a]); end
        end
        default: begin
          jstrobe(1, 0, 0, jdo_a(a, 0));
          jstrobe(0, 0, 1, jdo_b(d));
          wait_jtag_idle();
          shadow[a] = d;
        end
      endcase
    end
    for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) diffs++;
    total += 2;
    if (diffs != 0) begin bad++; $display("FAIL rnd_mem: got %0d differing words want 0", diffs); end
    if (jtag_overrun !== 1'b0) begin bad++; $display("FAIL rnd_overrun: got %b want 0", jtag_overrun); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    ram_rddata = '0;
    test_reset();
    test_jtag_read();
    test_jtag_write_wrap();
    test_av_read();
    test_debugaccess();
    test_arbitration();
    test_priority();
    test_overrun_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
